// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads and
// drives the IF/ID register, applying decode-stage branch/jump redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic [5:0]  opD,
    output logic [5:0]  functD,
    output logic        validD,
    output logic [31:0] pcF
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] hold_buf_r, hold_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic [31:0] pcplus4_r, pcplus4_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        redirect_s;
    logic [31:0] target_s;
    logic        deliver_s;
    logic [31:0] deliver_word_s;

    // Redirect decision: a stalled decode stage may hold stale operands, so it is ignored then
    always_comb begin
        redirect_s = valid_r && !stallD && (jumpD || pcsrcD);
        if (jumpD) begin
            target_s = {pcplus4_r[31:28], instr_r[25:0], 2'b00};
        end else begin
            target_s = pcbranchD;
        end
    end

    // Fetch FSM next state, imem request, PC and IF/ID next values
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        hold_nxt_s     = hold_buf_r;
        deliver_s      = 1'b0;
        deliver_word_s = hold_buf_r;
        imem_req       = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                imem_req = !stallF && !redirect_s;
                if (!stallF && !redirect_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A response coinciding with a redirect completes the request, so no KILL is needed
                if (imem_valid) begin
                    if (redirect_s) begin
                        state_nxt_s = ST_ISSUE;
                    end else if (stallD) begin
                        hold_nxt_s  = imem_rdata;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        deliver_s      = 1'b1;
                        deliver_word_s = imem_rdata;
                        state_nxt_s    = ST_ISSUE;
                    end
                end else if (redirect_s) begin
                    state_nxt_s = ST_KILL;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    state_nxt_s = ST_ISSUE;
                end else if (!stallD) begin
                    deliver_s   = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_KILL: begin
                if (imem_valid) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: begin
                state_nxt_s = ST_ISSUE;
            end
        endcase

        if (redirect_s) begin
            pc_nxt_s = target_s;
        end else if (deliver_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end

        if (stallD) begin
            instr_nxt_s   = instr_r;
            pcplus4_nxt_s = pcplus4_r;
            valid_nxt_s   = valid_r;
        end else if (deliver_s) begin
            instr_nxt_s   = deliver_word_s;
            pcplus4_nxt_s = pc_r + 32'd4;
            valid_nxt_s   = 1'b1;
        end else begin
            instr_nxt_s   = 32'h0000_0000;
            pcplus4_nxt_s = pcplus4_r;
            valid_nxt_s   = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_ISSUE;
            pc_r       <= RESET_PC;
            hold_buf_r <= 32'h0000_0000;
            instr_r    <= 32'h0000_0000;
            pcplus4_r  <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            hold_buf_r <= hold_nxt_s;
            instr_r    <= instr_nxt_s;
            pcplus4_r  <= pcplus4_nxt_s;
            valid_r    <= valid_nxt_s;
        end
    end

    assign imem_addr = pc_r;
    assign pcF       = pc_r;
    assign instrD    = instr_r;
    assign pcplus4D  = pcplus4_r;
    assign validD    = valid_r;
    assign opD       = instr_r[31:26];
    assign functD    = instr_r[5:0];

endmodule
